// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the light-stop game blocks
package game_pkg;

   localparam int LVL_W   = 3;
   localparam int LIVES_W = 2;
   localparam int MAX_LVL = 4;

   // Session controller states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RESUME = 3'd1,
      ST_PLAY   = 3'd2,
      ST_PULSE  = 3'd3,
      ST_CHECK  = 3'd4,
      ST_HOLD   = 3'd5,
      ST_DONE   = 3'd6,
      ST_OVER   = 3'd7
   } state_t;

   // Engine palette, GRB byte order as sent to the LED string
   typedef logic [23:0] grb_t;
   localparam grb_t CLR_OFF    = 24'h00_00_00;
   localparam grb_t CLR_RED    = 24'h00_FF_00;
   localparam grb_t CLR_ORANGE = 24'h80_FF_00;
   localparam grb_t CLR_GREEN  = 24'hFF_00_00;
   localparam grb_t CLR_CYAN   = 24'hFF_00_FF;
   localparam grb_t CLR_BLUE   = 24'h00_00_FF;
   localparam grb_t CLR_VIOLET = 24'h00_80_FF;

   // Level increment that sticks at the ceiling instead of wrapping
   function automatic logic [LVL_W-1:0] lvl_sat_inc(input logic [LVL_W-1:0] lvl,
                                                    input logic [LVL_W-1:0] lvl_max);
      return (lvl >= lvl_max) ? lvl_max : lvl + LVL_W'(1);
   endfunction

endpackage

// File: rtl/game_level_ctrl_if.sv
// rtl/game_level_ctrl_if.sv - board/engine signals seen by the session controller
interface game_level_ctrl_if;
   import game_pkg::*;

   logic               btn;
   logic               Flag;
   logic               Go;
   logic               Run;
   logic [LVL_W-1:0]   Lvl;
   logic [LIVES_W-1:0] Lives;
   logic               Win;
   logic               Over;

   // Controller side
   modport master (
      input  btn, Flag,
      output Go, Run, Lvl, Lives, Win, Over
   );

   // Board and engine side
   modport slave (
      output btn, Flag,
      input  Go, Run, Lvl, Lives, Win, Over
   );
endinterface

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - button synchronizer, debouncer and rising-edge press pulse
module btn_cond #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);
   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_level_d;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;
   logic             w_mismatch;

   assign w_mismatch = r_sync2 ^ r_level;

   // Two-flop synchronizer for the raw asynchronous button
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Level flips only after DEB_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else if (w_mismatch) begin
         if (r_cnt == C_CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end else begin
         r_cnt <= '0;
      end
   end

   // Single press pulse in the cycle after the debounced level rises
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/game_level_ctrl.sv
// rtl/game_level_ctrl.sv - light-stop session controller: levels, lives, Go pulses
module game_level_ctrl #(
   parameter int DEB_CYCLES  = 1000000,
   parameter int HOLD_CYCLES = 100000000,
   parameter int LIVES       = 3,
   parameter int MAX_LVL     = game_pkg::MAX_LVL
) (
   input  logic              clk,
   input  logic              reset,
   game_level_ctrl_if.master io_game
);
   import game_pkg::*;

   localparam int HOLD_W = ($clog2(HOLD_CYCLES + 1) > 27) ? $clog2(HOLD_CYCLES + 1) : 27;
   localparam logic [LVL_W-1:0]   C_MAX_LVL   = LVL_W'(MAX_LVL);
   localparam logic [LIVES_W-1:0] C_LIVES     = LIVES_W'(LIVES);
   localparam logic [HOLD_W-1:0]  C_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [LVL_W-1:0]   r_lvl;
   logic [LIVES_W-1:0] r_lives;
   logic [HOLD_W-1:0]  r_hold_cnt;
   logic               r_go;
   logic               r_run;
   logic               r_win;
   logic               r_over;
   logic               w_go;
   logic               w_run;
   logic               w_win;
   logic               w_over;
   logic               w_press;
   logic               w_level;
   logic               w_press_ok;
   logic               w_hold_done;

   btn_cond #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_btn_cond (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (io_game.btn),
      .o_level (w_level),
      .o_press (w_press)
   );

   // A press only counts while the debounced level still agrees it is held
   assign w_press_ok  = w_press & w_level;
   assign w_hold_done = (r_hold_cnt == C_HOLD_LAST);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; presses outside IDLE/PLAY/DONE/OVER are dropped
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_press_ok) w_state_nxt = ST_RESUME;
         ST_RESUME: if (!io_game.Flag) w_state_nxt = ST_PLAY;
         ST_PLAY:   if (w_press_ok) w_state_nxt = ST_PULSE;
         ST_PULSE:  w_state_nxt = ST_CHECK;
         ST_CHECK: begin
            if (io_game.Flag)                 w_state_nxt = ST_HOLD;
            else if (r_lives > LIVES_W'(1))   w_state_nxt = ST_PLAY;
            else                              w_state_nxt = ST_OVER;
         end
         ST_HOLD: begin
            if (w_hold_done) begin
               w_state_nxt = (r_lvl == C_MAX_LVL) ? ST_DONE : ST_RESUME;
            end
         end
         ST_DONE,
         ST_OVER:   if (w_press_ok) w_state_nxt = ST_RESUME;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Moore outputs decoded from the upcoming state so they can be registered
   always_comb begin
      w_go   = (w_state_nxt == ST_PULSE);
      w_run  = (w_state_nxt == ST_RESUME) || (w_state_nxt == ST_PLAY) ||
               (w_state_nxt == ST_PULSE)  || (w_state_nxt == ST_CHECK);
      w_win  = (w_state_nxt == ST_DONE);
      w_over = (w_state_nxt == ST_OVER);
   end

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_go   <= 1'b0;
         r_run  <= 1'b0;
         r_win  <= 1'b0;
         r_over <= 1'b0;
      end else begin
         r_go   <= w_go;
         r_run  <= w_run;
         r_win  <= w_win;
         r_over <= w_over;
      end
   end

   // Level, lives and hold timer; the timer restarts from zero on every HOLD entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lvl      <= '0;
         r_lives    <= C_LIVES;
         r_hold_cnt <= '0;
      end else begin
         if (r_state == ST_HOLD) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
         end else begin
            r_hold_cnt <= '0;
         end
         case (r_state)
            ST_CHECK: begin
               if (!io_game.Flag && (r_lives != '0)) begin
                  r_lives <= r_lives - LIVES_W'(1);
               end
            end
            ST_HOLD: begin
               if (w_hold_done && (r_lvl != C_MAX_LVL)) begin
                  r_lvl <= lvl_sat_inc(r_lvl, C_MAX_LVL);
               end
            end
            ST_DONE,
            ST_OVER: begin
               if (w_press_ok) begin
                  r_lvl   <= '0;
                  r_lives <= C_LIVES;
               end
            end
            default: ;
         endcase
      end
   end

   assign io_game.Go    = r_go;
   assign io_game.Run   = r_run;
   assign io_game.Lvl   = r_lvl;
   assign io_game.Lives = r_lives;
   assign io_game.Win   = r_win;
   assign io_game.Over  = r_over;

endmodule
